exp_result_buf: RTL and testbench

Sits directly downstream of the exponential datapath/controller pair. Captures each 18-bit Q2.16 e^x result from the datapath's `rBus` when the controller pulses `done`, and queues it in a small FIFO. Presents results to the consumer on a valid/ready interface. Drives `full` back to the controller so no new computation starts while there is nowhere to put its result.

---
 rtl/exp_pkg.sv | 20 ++
 rtl/exp_result_buf.sv | 143 ++++++++++++++
 tb/tb_exp_result_buf.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/exp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : exp_pkg
// Description : Shared constants and result type for the exponential unit
//               (datapath, controller, result buffer and their benches).
// Revision    : 1.0 - initial release
// ============================================================================
package exp_pkg;

  // Result format is unsigned Q2.16
  localparam int EXP_RES_W  = 18;
  localparam int EXP_FRAC_W = 16;

  // 1.0 in Q2.16, i.e. e^0
  localparam logic [EXP_RES_W-1:0] ONE_Q2_16 = 18'h10000;

  typedef logic [EXP_RES_W-1:0] exp_res_t;

endpackage : exp_pkg
`default_nettype wire

// File: rtl/exp_result_buf.sv
`default_nettype none
// ============================================================================
// Module      : exp_result_buf
// Description : Result FIFO behind the exponential datapath. Captures rBus on
//               each controller 'done' pulse, presents results on a
//               valid/ready port, back-pressures the controller via 'full'
//               and flags dropped results with a sticky 'ovf'.
//               Optional macro EXP_RES_PEAK_EN adds a running unsigned
//               maximum of accepted results on port 'peak'.
// Revision    : 1.0 - initial release
// ============================================================================
module exp_result_buf
  import exp_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = EXP_RES_W
) (
  input  logic                     clk,
  input  logic                     rst,        // async, active-low
  input  logic                     done,
  input  logic [WIDTH-1:0]         rBus,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic                     ovf,
`ifdef EXP_RES_PEAK_EN
  output logic [WIDTH-1:0]         peak,
`endif
  input  logic                     clr_ovf
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;

  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;

  // Status is derived from the registered occupancy only
  assign w_full  = (count_q == C_DEPTH);
  assign w_empty = (count_q == '0);

  // A pop frees a slot in the same cycle, so a full FIFO can still accept
  assign w_pop  = !w_empty && out_ready;
  assign w_push = done && (!w_full || w_pop);

  assign full      = w_full;
  assign empty     = w_empty;
  assign count     = count_q;
  assign out_valid = !w_empty;
  assign out_data  = mem_q[rd_ptr_q];
  assign ovf       = ovf_q;

  // Next-state for storage, pointers, occupancy and the overflow flag
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;

    if (w_push) begin
      mem_d[wr_ptr_q] = rBus;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (w_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    if (w_push && !w_pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (w_pop && !w_push) begin
      count_d = count_q - CNT_W'(1);
    end

    // A drop in the same cycle as the clear must leave the flag set
    if (clr_ovf) begin
      ovf_d = 1'b0;
    end
    if (done && !w_push) begin
      ovf_d = 1'b1;
    end
  end

  // State registers with asynchronous active-low clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

`ifdef EXP_RES_PEAK_EN
  logic [WIDTH-1:0] peak_q, peak_d;

  assign peak = peak_q;

  // Running unsigned maximum of accepted results; a push beats a clear
  always_comb begin
    peak_d = peak_q;
    if (clr_ovf) begin
      peak_d = '0;
    end
    if (w_push && (clr_ovf || (rBus > peak_q))) begin
      peak_d = rBus;
    end
  end

  // Peak register with asynchronous active-low clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      peak_q <= '0;
    end else begin
      peak_q <= peak_d;
    end
  end
`endif

endmodule : exp_result_buf
`default_nettype wire

// File: tb/tb_exp_result_buf.sv
`default_nettype none
// ============================================================================
// Module      : tb_exp_result_buf
// Description : Directed self-checking bench for exp_result_buf with a
//               queue-based reference model compared every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_exp_result_buf;
  import exp_pkg::*;

  localparam int DEPTH = 4;
  localparam int WIDTH = EXP_RES_W;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             done = 1'b0;
  logic [WIDTH-1:0] rBus = '0;
  logic             out_ready = 1'b0;
  logic             clr_ovf = 1'b0;
  logic             full, empty, out_valid, ovf;
  logic [2:0]       count;
  logic [WIDTH-1:0] out_data;
`ifdef EXP_RES_PEAK_EN
  logic [WIDTH-1:0] peak;
`endif

  exp_result_buf #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .done      (done),
    .rBus      (rBus),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .ovf       (ovf),
`ifdef EXP_RES_PEAK_EN
    .peak      (peak),
`endif
    .clr_ovf   (clr_ovf)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  // Reference model: plain queue of stored results plus flags
  exp_res_t   m_q[$];
  logic       m_ovf  = 1'b0;
  exp_res_t   m_peak = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_q.delete();
    m_ovf  = 1'b0;
    m_peak = '0;
  endtask

  // One clock: advance the model from the inputs present at the edge
  task automatic cycle();
    bit is_full, do_pop, do_push;
    @(posedge clk);
    is_full = (m_q.size() == DEPTH);
    do_pop  = (m_q.size() > 0) && out_ready;
    do_push = done && (!is_full || do_pop);
    if (do_pop) void'(m_q.pop_front());
    if (do_push) m_q.push_back(rBus);
    if (clr_ovf) m_ovf = 1'b0;
    if (done && !do_push) m_ovf = 1'b1;
    if (clr_ovf) m_peak = '0;
    if (do_push && (clr_ovf || rBus > m_peak)) m_peak = rBus;
    #1;
  endtask

  // Every-cycle comparison of the DUT against the model
  always @(negedge clk) begin
    if (chk_en && rst) begin
      chk("m_count", 32'(count), 32'(m_q.size()));
      chk("m_empty", 32'(empty), 32'(m_q.size() == 0));
      chk("m_full", 32'(full), 32'(m_q.size() == DEPTH));
      chk("m_valid", 32'(out_valid), 32'(m_q.size() > 0));
      chk("m_ovf", 32'(ovf), 32'(m_ovf));
      if (m_q.size() > 0) chk("m_data", 32'(out_data), 32'(m_q[0]));
`ifdef EXP_RES_PEAK_EN
      chk("m_peak", 32'(peak), 32'(m_peak));
`endif
    end
  end

  task automatic push_one(input exp_res_t v, input logic rdy);
    done = 1'b1; rBus = v; out_ready = rdy;
    cycle();
    done = 1'b0; out_ready = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_empty"}, 32'(empty), 32'd1);
    chk({tag, "_full"}, 32'(full), 32'd0);
    chk({tag, "_count"}, 32'(count), 32'd0);
    chk({tag, "_ovf"}, 32'(ovf), 32'd0);
    chk({tag, "_data"}, 32'(out_data), 32'd0);
  endtask

  initial begin
    exp_res_t drain_exp [4];

    // Asynchronous reset, applied between clock edges
    #3 rst = 1'b0;
    model_reset();
    #1 check_reset_outputs("rst0");
    cycle(); cycle();
    rst = 1'b1;
    chk_en = 1'b1;
    cycle();

    // Single push, consumer stalled; no bypass in the done cycle
    done = 1'b1; rBus = ONE_Q2_16;
    #1 chk("nobypass_valid", 32'(out_valid), 32'd0);
    cycle();
    done = 1'b0;
    chk("single_valid", 32'(out_valid), 32'd1);
    chk("single_data", 32'(out_data), 32'h10000);
    chk("single_count", 32'(count), 32'd1);
    for (int i = 0; i < 5; i++) cycle();
    chk("hold_data", 32'(out_data), 32'h10000);
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    chk("single_drained", 32'(empty), 32'd1);

    // Empty FIFO with ready high: nothing pops
    out_ready = 1'b1;
    cycle(); cycle();
    out_ready = 1'b0;
    chk("empty_ready_count", 32'(count), 32'd0);

    // Fill to DEPTH
    push_one(18'h10000, 1'b0);
    push_one(18'h1A612, 1'b0);
    push_one(18'h2B7E1, 1'b0);
    push_one(18'h012E1, 1'b0);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_count", 32'(count), 32'd4);

    // Overflow drops the result and sets the sticky flag
    push_one(18'h3FFFF, 1'b0);
    chk("ovf_set", 32'(ovf), 32'd1);
    chk("ovf_count", 32'(count), 32'd4);
    chk("ovf_head", 32'(out_data), 32'h10000);
    clr_ovf = 1'b1; cycle(); clr_ovf = 1'b0;
    chk("ovf_clr", 32'(ovf), 32'd0);

    // Clear and overflow together: overflow wins
    clr_ovf = 1'b1; done = 1'b1; rBus = 18'h3FFFF;
    cycle();
    clr_ovf = 1'b0; done = 1'b0;
    chk("ovf_wins", 32'(ovf), 32'd1);
    clr_ovf = 1'b1; cycle(); clr_ovf = 1'b0;

    // Full with simultaneous push and pop
    push_one(18'h00ABC, 1'b1);
    chk("fullpp_count", 32'(count), 32'd4);
    chk("fullpp_ovf", 32'(ovf), 32'd0);

    // Drain: order preserved, new value is the 4th entry
    drain_exp[0] = 18'h1A612; drain_exp[1] = 18'h2B7E1;
    drain_exp[2] = 18'h012E1; drain_exp[3] = 18'h00ABC;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain%0d", i), 32'(out_data), 32'(drain_exp[i]));
      cycle();
    end
    out_ready = 1'b0;
    chk("drain_empty", 32'(empty), 32'd1);

    // Empty with done and ready: push only
    push_one(18'h1A612, 1'b1);
    chk("emptypp_count", 32'(count), 32'd1);
    out_ready = 1'b1; cycle(); out_ready = 1'b0;

    // Running peak, then clear-with-push
    clr_ovf = 1'b1; cycle(); clr_ovf = 1'b0;
    push_one(18'h1A612, 1'b1);
    push_one(18'h10000, 1'b1);
    push_one(18'h2B7E1, 1'b1);
`ifdef EXP_RES_PEAK_EN
    chk("peak_max", 32'(peak), 32'h2B7E1);
`endif
    clr_ovf = 1'b1;
    push_one(18'h10000, 1'b1);
    clr_ovf = 1'b0;
`ifdef EXP_RES_PEAK_EN
    chk("peak_clr_push", 32'(peak), 32'h10000);
`endif
    out_ready = 1'b1; cycle(); cycle(); out_ready = 1'b0;

    // Reset in the middle of traffic
    push_one(18'h2B7E1, 1'b0);
    push_one(18'h012E1, 1'b0);
    chk("pre_rst_count", 32'(count), 32'd2);
    #2 rst = 1'b0;
    model_reset();
    #1 check_reset_outputs("rst1");
    cycle();
    rst = 1'b1;
    cycle(); cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_exp_result_buf
`default_nettype wire
